// File: rtl/sram_controller.sv
// Word-wide MEM-stage requests executed as two half-word accesses
// on the 16-bit DE2 SRAM, low half first; ready stays low until done.
module sram_controller #(
   parameter int BASE_ADDR     = 1024,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N
);

   localparam int CW =
      (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          op_wr, op_wr_nx;
   logic          req;
   logic          last;
   logic          drive;
   logic [15:0]   dq_out;
   logic [31:0]   offset;
   logic          unused_bits;

   assign req         = mem_r_en | mem_w_en;
   assign last        = (cnt == LAST);
   assign offset      = address - 32'(BASE_ADDR);
   assign unused_bits = ^{offset[31:19], offset[1:0]};
   assign SRAM_DQ     = drive ? dq_out : 16'bz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_wr     <= 1'b0;
         read_data <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         op_wr <= op_wr_nx;
         // sample the bus on the edge that closes each read phase
         if (!op_wr && last) begin
            if (state == LO)
               read_data[15:0] <= SRAM_DQ;
            else if (state == HI)
               read_data[31:16] <= SRAM_DQ;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      op_wr_nx  = op_wr;
      ready     = 1'b0;
      drive     = 1'b0;
      dq_out    = write_data[15:0];
      SRAM_ADDR = '0;
      SRAM_UB_N = 1'b1;
      SRAM_LB_N = 1'b1;
      SRAM_WE_N = 1'b1;
      SRAM_CE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      unique case (state)
         IDLE: begin
            ready  = !req;
            cnt_nx = '0;
            if (req) begin
               state_nx = LO;
               op_wr_nx = mem_w_en;
            end
         end
         LO, HI: begin
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_ADDR = {offset[18:2], state == HI};
            SRAM_OE_N = op_wr;
            // WE released on the last cycle so data holds past it
            SRAM_WE_N = !op_wr || last;
            drive     = op_wr;
            dq_out    = (state == HI) ? write_data[31:16]
                                      : write_data[15:0];
            if (last) begin
               cnt_nx   = '0;
               state_nx = (state == LO) ? HI : DONE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: begin
            ready    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
